// File: rtl/fm_cmn_pkg.sv
// Shared encodings for the fm_cmn FIFO-side blocks.
// State values are fixed so the debug state port decodes the same way everywhere.
package fm_cmn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/fm_cmn_bififo_burst_rd.sv
// Drains a show-ahead FIFO into fixed-length memory write bursts (request, then data beats).
// Handshake: o_req holds address/length until i_ack; a beat transfers when o_wdvalid && i_wdack.
module fm_cmn_bififo_burst_rd
  import fm_cmn_pkg::*;
#(
  parameter int P_WIDTH  = 32,
  parameter int P_RANGE  = 8,
  parameter int P_BLEN   = 8,
  parameter int P_AWIDTH = 30
) (
  input  logic                clk_core,
  input  logic                rst_x,
  input  logic                i_start,
  input  logic [P_AWIDTH-1:0] i_base_adrs,
  input  logic                i_stop,
  input  logic                i_flush,
  output logic                o_busy,
  input  logic                i_fifo_empty,
  input  logic [P_RANGE:0]    i_fifo_dnum,
  input  logic [P_WIDTH-1:0]  i_fifo_dt,
  output logic                o_fifo_renable,
  output logic                o_req,
  output logic [P_AWIDTH-1:0] o_adrs,
  output logic [P_RANGE:0]    o_len,
  input  logic                i_ack,
  output logic                o_wdvalid,
  output logic [P_WIDTH-1:0]  o_wd,
  input  logic                i_wdack,
  output logic [1:0]          o_dbg_state
);

  localparam int LW = P_RANGE + 1;
  localparam logic [LW-1:0] BLEN_W = LW'(P_BLEN);

  state_e              state_q, state_d;
  logic                active_q, active_d;
  logic                stop_pend_q, stop_pend_d;
  logic [P_AWIDTH-1:0] adrs_q, adrs_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       beat_q, beat_d;

  logic go_full, go_flush, beat_ok, last_beat;

  assign go_full   = active_q && (i_fifo_dnum >= BLEN_W);
  assign go_flush  = active_q && i_flush && (i_fifo_dnum != '0);
  assign beat_ok   = (state_q == ST_DATA) && !i_fifo_empty && i_wdack;
  assign last_beat = beat_ok && (beat_q == LW'(1));

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go_full || go_flush) state_d = ST_REQ;
      ST_REQ:  if (i_ack)               state_d = ST_DATA;
      ST_DATA: if (last_beat)           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (state_q != ST_IDLE);
    o_req          = (state_q == ST_REQ);
    o_adrs         = (state_q == ST_REQ) ? adrs_q : '0;
    o_len          = (state_q == ST_REQ) ? len_q : '0;
    o_wdvalid      = (state_q == ST_DATA) && !i_fifo_empty;
    o_wd           = (state_q == ST_DATA) ? i_fifo_dt : '0;
    o_fifo_renable = beat_ok;
    o_dbg_state    = state_q;
  end

  // A stop seen mid-burst is parked so the active flag only drops back in IDLE.
  always_comb begin
    active_d    = active_q;
    stop_pend_d = stop_pend_q;
    adrs_d      = adrs_q;
    len_d       = len_q;
    beat_d      = beat_q;
    if (state_q == ST_IDLE) begin
      stop_pend_d = 1'b0;
      if (i_start) begin
        active_d = 1'b1;
        adrs_d   = i_base_adrs;
      end else if (i_stop) begin
        active_d = 1'b0;
      end
      if (go_full)       len_d = BLEN_W;
      else if (go_flush) len_d = i_fifo_dnum;
    end else if (i_stop) begin
      stop_pend_d = 1'b1;
    end
    if ((state_q == ST_REQ) && i_ack) beat_d = len_q;
    if (beat_ok) begin
      beat_d = beat_q - LW'(1);
      if (last_beat) begin
        adrs_d = adrs_q + P_AWIDTH'(len_q);
        if (stop_pend_q || i_stop) begin
          active_d    = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      active_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      adrs_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
    end else begin
      active_q    <= active_d;
      stop_pend_q <= stop_pend_d;
      adrs_q      <= adrs_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
    end
  end

endmodule
